// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding and counter sizing.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ASSERT    = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    DONE      = 2'd3
  } rst_seq_state_t;

  // Counter must reach max(hold, gap) - 1; never narrower than one bit.
  function automatic int cnt_width(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/reset_sequencer_sync.sv
// Generic async-reset flop-chain synchronizer for a single-bit level signal.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Orders reset release across DOMAINS domains: hold, wait for stable PLL lock, then release
// one domain every GAP_CYCLES, lowest index first, and flag completion.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int DOMAINS     = 4,
  parameter int STAGES      = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               pll_lock_i,
  input  logic               sw_rst_i,
  output logic [DOMAINS-1:0] nrst_o,
  output logic               rst_done_o,
  output logic [1:0]         state_o
);

  localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam int IW = (DOMAINS > 1) ? $clog2(DOMAINS) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DOMAINS - 1);

  rst_seq_state_t     state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [DOMAINS-1:0] nrst_q, nrst_d;
  logic               done_q, done_d;
  logic               lock_s;
  logic               abort;

  sync_ff #(.STAGES(STAGES), .RESET_VAL(1'b0)) u_lock_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (pll_lock_i),
    .q_o   (lock_s)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      nrst_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      nrst_q  <= nrst_d;
      done_q  <= done_d;
    end
  end

  // Losing lock only matters once we have left WAIT_LOCK; abort beats any advance.
  assign abort = (state_q != ASSERT) &&
                 (sw_rst_i || (!lock_s && (state_q != WAIT_LOCK)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    nrst_d  = nrst_q;
    done_d  = done_q;
    if (abort) begin
      state_d = ASSERT;
      cnt_d   = '0;
      idx_d   = '0;
      nrst_d  = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ASSERT: begin
          nrst_d = '0;
          done_d = 1'b0;
          if (sw_rst_i) begin
            cnt_d = '0;
          end else if (cnt_q == HOLD_LAST) begin
            cnt_d   = '0;
            state_d = WAIT_LOCK;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            nrst_d  = DOMAINS'(1);
            idx_d   = '0;
            cnt_d   = '0;
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            if (idx_q != IDX_LAST) begin
              idx_d  = idx_q + IW'(1);
              nrst_d = (nrst_q << 1) | DOMAINS'(1);
            end else begin
              done_d  = 1'b1;
              state_d = DONE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DONE: begin
          nrst_d = '1;
          done_d = 1'b1;
        end
        default: state_d = ASSERT;
      endcase
    end
  end

  assign nrst_o     = nrst_q;
  assign rst_done_o = done_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: release timing, lock handling, software and async resets.
`timescale 1ns/1ps
module tb_reset_sequencer;
  import reset_sequencer_pkg::*;

  localparam logic [1:0] S_ASSERT = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_REL    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic       pllLock;
  logic       swRst;
  logic [3:0] nrst;
  logic       rstDone;
  logic [1:0] state;
  int         checks = 0;
  int         failures = 0;
  int         edgeCnt;

  reset_sequencer #(
    .DOMAINS(4), .STAGES(2), .HOLD_CYCLES(16), .GAP_CYCLES(8)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .pll_lock_i (pllLock),
    .sw_rst_i   (swRst),
    .nrst_o     (nrst),
    .rst_done_o (rstDone),
    .state_o    (state)
  );

  always #2 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) edgeCnt <= 0;
    else     edgeCnt <= edgeCnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Invariants re-checked on every output change; posedges fall at t = 2 mod 4.
  always @(nrst or rstDone or state) begin
    if (!$isunknown({nrst, rstDone, state})) begin
      checkOutput("thermometer", 32'(((nrst + 4'd1) & nrst) == 4'd0), 32'd1);
      checkOutput("doneImpliesAll", 32'(!rstDone || (nrst == 4'hF)), 32'd1);
      checkOutput("edgeAligned", 32'(rst || (($time % 4) == 2)), 32'd1);
    end
  end

  task automatic stepTo(input int n);
    while (edgeCnt < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expectAt(input int n, input logic [3:0] expNrst, input logic expDone,
                          input logic [1:0] expState, input string tag);
    stepTo(n);
    checkOutput($sformatf("%s nrst@%0d", tag, n), 32'(nrst), 32'(expNrst));
    checkOutput($sformatf("%s done@%0d", tag, n), 32'(rstDone), 32'(expDone));
    checkOutput($sformatf("%s state@%0d", tag, n), 32'(state), 32'(expState));
  endtask

  task automatic applyStimulus(input logic lockLevel);
    pllLock = lockLevel;
    swRst   = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset nrst", 32'(nrst), 32'h0);
    checkOutput("reset done", 32'(rstDone), 32'h0);
    checkOutput("reset state", 32'(state), 32'(S_ASSERT));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pllLock = 1'b0;
    swRst = 1'b0;

    $display("[TB] power-up with stable lock");
    applyStimulus(1'b1);
    expectAt(16, 4'b0000, 1'b0, S_WAIT,   "pwr");
    expectAt(17, 4'b0001, 1'b0, S_REL,    "pwr");
    expectAt(24, 4'b0001, 1'b0, S_REL,    "pwr");
    expectAt(25, 4'b0011, 1'b0, S_REL,    "pwr");
    expectAt(33, 4'b0111, 1'b0, S_REL,    "pwr");
    expectAt(40, 4'b0111, 1'b0, S_REL,    "pwr");
    expectAt(41, 4'b1111, 1'b0, S_REL,    "pwr");
    expectAt(48, 4'b1111, 1'b0, S_REL,    "pwr");
    expectAt(49, 4'b1111, 1'b1, S_DONE,   "pwr");
    expectAt(55, 4'b1111, 1'b1, S_DONE,   "pwr");

    $display("[TB] lock loss mid-release, then software pulse in DONE");
    applyStimulus(1'b1);
    expectAt(26, 4'b0011, 1'b0, S_REL,    "lossPre");
    pllLock = 1'b0;
    expectAt(29, 4'b0000, 1'b0, S_ASSERT, "loss");
    pllLock = 1'b1;
    expectAt(45, 4'b0000, 1'b0, S_WAIT,   "replay");
    expectAt(46, 4'b0001, 1'b0, S_REL,    "replay");
    expectAt(54, 4'b0011, 1'b0, S_REL,    "replay");
    expectAt(77, 4'b1111, 1'b0, S_REL,    "replay");
    expectAt(78, 4'b1111, 1'b1, S_DONE,   "replay");
    stepTo(80);
    swRst = 1'b1;
    stepTo(81);
    swRst = 1'b0;
    expectAt(81, 4'b0000, 1'b0, S_ASSERT, "swDone");
    expectAt(97, 4'b0000, 1'b0, S_WAIT,   "swDone");
    expectAt(98, 4'b0001, 1'b0, S_REL,    "swDone");

    $display("[TB] software pulse in ASSERT at cnt=10");
    applyStimulus(1'b1);
    stepTo(10);
    swRst = 1'b1;
    stepTo(11);
    swRst = 1'b0;
    expectAt(17, 4'b0000, 1'b0, S_ASSERT, "swHold");
    expectAt(27, 4'b0000, 1'b0, S_WAIT,   "swHold");
    expectAt(28, 4'b0001, 1'b0, S_REL,    "swHold");

    $display("[TB] late PLL lock");
    applyStimulus(1'b0);
    expectAt(16, 4'b0000, 1'b0, S_WAIT,   "late");
    expectAt(30, 4'b0000, 1'b0, S_WAIT,   "late");
    pllLock = 1'b1;
    expectAt(32, 4'b0000, 1'b0, S_WAIT,   "late");
    expectAt(33, 4'b0001, 1'b0, S_REL,    "late");
    expectAt(41, 4'b0011, 1'b0, S_REL,    "late");
    expectAt(57, 4'b1111, 1'b0, S_REL,    "late");
    expectAt(65, 4'b1111, 1'b1, S_DONE,   "late");

    $display("[TB] async reset mid-release");
    applyStimulus(1'b1);
    expectAt(30, 4'b0011, 1'b0, S_REL,    "async");
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async nrst", 32'(nrst), 32'h0);
    checkOutput("async done", 32'(rstDone), 32'h0);
    checkOutput("async state", 32'(state), 32'(S_ASSERT));
    #8;
    rst = 1'b0;
    #8;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
